// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: display end of the HD44780-style 8-bit LCD bus.
// Decodes bus accesses, holds DDRAM and the address counter, models busy time.
module lcd_bus_responder #(
    parameter int unsigned CMD_CYCLES   = 2000,
    parameter int unsigned CLEAR_CYCLES = 76500,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       lcd_E,
    input  logic       lcd_RS,
    input  logic       lcd_RW,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    output logic       busy,
    output logic       cmd_strobe,
    output logic       cmd_rs,
    output logic [7:0] cmd_byte,
    output logic       write_err,
    input  logic [6:0] dbg_addr,
    output logic [7:0] dbg_char
);
    localparam int unsigned MAXC =
        (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int unsigned CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] CMD_LOAD = CW'(CMD_CYCLES);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [6:0] LAST_IDX = 7'd79;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_CLEAR,
        ST_INIT
    } state_e;

    function automatic logic is_mapped(input logic [6:0] a);
        return (a < 7'h28) || ((a >= 7'h40) && (a < 7'h68));
    endfunction

    function automatic logic [6:0] to_idx(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
        end else begin
            r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end
        return r;
    endfunction

    logic [10:0]   sync_q [SYNC_STAGES];
    logic          e_prev_q;
    logic          e_s, rs_s, rw_s, e_rise, e_fall;
    logic [7:0]    d_s;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    idx_q, idx_d;
    logic          init_req_q, init_req_d;
    logic [6:0]    ac_q, ac_d;
    logic          id_q, id_d;
    logic [2:0]    func_q, func_d;
    logic [2:0]    disp_q, disp_d;
    logic          rs_lat_q, rs_lat_d;
    logic          rw_lat_q, rw_lat_d;
    logic [7:0]    dout_q, dout_d;
    logic          oe_q, oe_d;
    logic          strobe_q, strobe_d;
    logic          cmd_rs_q, cmd_rs_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic          err_q, err_d;
    logic [7:0]    dbg_q;

    logic [7:0]    ddram_q [80];
    logic          mem_we;
    logic [6:0]    mem_idx;
    logic [7:0]    mem_wdata;

    logic          busy_w, ac_ok;
    logic [6:0]    ac_idx;
    logic [7:0]    ac_byte;
    logic          unused_cfg;

    assign e_s    = sync_q[SYNC_STAGES-1][10];
    assign rs_s   = sync_q[SYNC_STAGES-1][9];
    assign rw_s   = sync_q[SYNC_STAGES-1][8];
    assign d_s    = sync_q[SYNC_STAGES-1][7:0];
    assign e_rise = e_s & ~e_prev_q;
    assign e_fall = ~e_s & e_prev_q;

    assign busy_w  = (state_q != ST_IDLE);
    assign ac_ok   = is_mapped(ac_q);
    assign ac_idx  = to_idx(ac_q);
    assign ac_byte = ac_ok ? ddram_q[ac_idx] : 8'h00;

    // Display/function settings are held for completeness but drive nothing.
    assign unused_cfg = ^{func_q, disp_q};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            e_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_E, lcd_RS, lcd_RW, lcd_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            e_prev_q <= e_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        init_req_d = init_req_q;
        ac_d       = ac_q;
        id_d       = id_q;
        func_d     = func_q;
        disp_d     = disp_q;
        rs_lat_d   = rs_lat_q;
        rw_lat_d   = rw_lat_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        strobe_d   = 1'b0;
        cmd_rs_d   = cmd_rs_q;
        cmd_byte_d = cmd_byte_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_idx    = idx_q;
        mem_wdata  = 8'h20;

        unique case (state_q)
            ST_IDLE: begin
                if (init_req_q) begin
                    state_d    = ST_INIT;
                    idx_d      = '0;
                    init_req_d = 1'b0;
                end
            end
            ST_EXEC: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
                if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                cnt_d = (cnt_q != '0) ? cnt_q - CNT_ONE : '0;
                if (idx_q <= LAST_IDX) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + 7'd1;
                end
                if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
            end
            ST_INIT: begin
                mem_we = 1'b1;
                idx_d  = idx_q + 7'd1;
                if (idx_q == LAST_IDX) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (e_rise) begin
            rs_lat_d = rs_s;
            rw_lat_d = rw_s;
            if (rw_s) begin
                oe_d   = 1'b1;
                dout_d = rs_s ? ac_byte : {busy_w, ac_q};
            end
        end

        // Busy is taken from the state register, i.e. before this cycle's decrement.
        if (e_fall) begin
            oe_d = 1'b0;
            if (rw_lat_q) begin
                if (rs_lat_q && !busy_w) ac_d = ac_step(ac_q, id_q);
            end else if (busy_w || init_req_q) begin
                err_d = 1'b1;
            end else begin
                strobe_d   = 1'b1;
                cmd_rs_d   = rs_lat_q;
                cmd_byte_d = d_s;
                state_d    = ST_EXEC;
                cnt_d      = CMD_LOAD;
                if (rs_lat_q) begin
                    mem_we    = ac_ok;
                    mem_idx   = ac_idx;
                    mem_wdata = d_s;
                    ac_d      = ac_step(ac_q, id_q);
                end else begin
                    priority casez (d_s)
                        8'b1???????: ac_d = d_s[6:0];
                        8'b01??????: begin end
                        8'b001?????: func_d = d_s[4:2];
                        8'b0001????: begin end
                        8'b00001???: disp_d = d_s[2:0];
                        8'b000001??: id_d = d_s[1];
                        8'b0000001?: ac_d = 7'h00;
                        8'b00000001: begin
                            ac_d    = 7'h00;
                            id_d    = 1'b1;
                            state_d = ST_CLEAR;
                            cnt_d   = CLR_LOAD;
                            idx_d   = '0;
                        end
                        8'b00000000: begin end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            init_req_q <= 1'b1;
            ac_q       <= 7'h00;
            id_q       <= 1'b1;
            func_q     <= '0;
            disp_q     <= '0;
            rs_lat_q   <= 1'b0;
            rw_lat_q   <= 1'b0;
            dout_q     <= 8'h00;
            oe_q       <= 1'b0;
            strobe_q   <= 1'b0;
            cmd_rs_q   <= 1'b0;
            cmd_byte_q <= 8'h00;
            err_q      <= 1'b0;
            dbg_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            init_req_q <= init_req_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            func_q     <= func_d;
            disp_q     <= disp_d;
            rs_lat_q   <= rs_lat_d;
            rw_lat_q   <= rw_lat_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            strobe_q   <= strobe_d;
            cmd_rs_q   <= cmd_rs_d;
            cmd_byte_q <= cmd_byte_d;
            err_q      <= err_d;
            dbg_q      <= is_mapped(dbg_addr) ? ddram_q[to_idx(dbg_addr)] : 8'h00;
        end
    end

    // DDRAM has no reset port; the post-reset init loop fills it with spaces.
    always_ff @(posedge clk_clk) begin
        if (mem_we) ddram_q[mem_idx] <= mem_wdata;
    end

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign busy         = busy_w;
    assign cmd_strobe   = strobe_q;
    assign cmd_rs       = cmd_rs_q;
    assign cmd_byte     = cmd_byte_q;
    assign write_err    = err_q;
    assign dbg_char     = dbg_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Scoreboard bench for lcd_bus_responder: random bus traffic checked
// against an address-level DDRAM/AC model.
module tb_lcd_bus_responder;
    localparam int CMD = 20;
    localparam int CLR = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       E = 1'b0, RS = 1'b0, RW = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       oe, busy, strobe, crs, werr;
    logic [7:0] cbyte, dbg_char;
    logic [6:0] dbg_addr = 7'h00;

    always #5 clk = ~clk;

    lcd_bus_responder #(
        .CMD_CYCLES(CMD), .CLEAR_CYCLES(CLR), .SYNC_STAGES(2)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .lcd_E(E), .lcd_RS(RS), .lcd_RW(RW), .lcd_data_in(din),
        .lcd_data_out(dout), .lcd_data_oe(oe), .busy(busy),
        .cmd_strobe(strobe), .cmd_rs(crs), .cmd_byte(cbyte),
        .write_err(werr), .dbg_addr(dbg_addr), .dbg_char(dbg_char)
    );

    int n_tests = 0;
    int n_fail = 0;
    logic [8:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] mem [128];
    logic [6:0] m_ac;
    logic       m_id;
    int busy_run = 0;
    int last_run = 0;
    logic oe_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic mapped(input logic [6:0] a);
        return (a <= 7'd39) || (a >= 7'd64 && a <= 7'd103);
    endfunction

    function automatic logic [6:0] next_ac(input logic [6:0] a, input logic inc);
        int v;
        v = inc ? int'(a) + 1 : int'(a) - 1;
        if (inc && a == 7'd39) v = 64;
        if (inc && a == 7'd103) v = 0;
        if (!inc && a == 7'd0) v = 103;
        if (!inc && a == 7'd64) v = 39;
        return 7'(v & 127);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mem[i] = 8'h20;
        m_ac = 7'h00;
        m_id = 1'b1;
    endtask

    task automatic model_write(input logic rs, input logic [7:0] b);
        if (rs) begin
            if (mapped(m_ac)) mem[m_ac] = b;
            m_ac = next_ac(m_ac, m_id);
        end else if (b[7]) m_ac = b[6:0];
        else if (b[6:3] != 4'b0000) begin end
        else if (b[2]) m_id = b[1];
        else if (b[1]) m_ac = 7'h00;
        else if (b[0]) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'h20;
            m_ac = 7'h00;
            m_id = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_run++;
        else begin
            if (busy_run != 0) last_run = busy_run;
            busy_run = 0;
        end
        if (strobe) begin
            if (exp_wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got rs=%0b byte=0x%0h, expected no strobe", crs, cbyte);
            end else begin
                check("strobe_rs_byte", {crs, cbyte}, exp_wr_q.pop_front());
                check("busy_with_strobe", busy, 1);
            end
        end
        if (oe && !oe_prev) begin
            if (exp_rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_read: got 0x%0h, expected no read", dout);
            end else begin
                check("read_data", dout, exp_rd_q.pop_front());
            end
        end
        oe_prev = oe;
    end

    task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        RS = rs;
        RW = rw;
        din = d;
        @(negedge clk);
        E = 1'b1;
        repeat (4) @(negedge clk);
        E = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wr(input logic rs, input logic [7:0] b);
        exp_wr_q.push_back({rs, b});
        model_write(rs, b);
        bus_cycle(rs, 1'b0, b);
        repeat ((!rs && b == 8'h01) ? CLR : CMD) @(negedge clk);
    endtask

    task automatic rd(input logic rs);
        logic [7:0] e;
        if (rs) begin
            e = mapped(m_ac) ? mem[m_ac] : 8'h00;
            m_ac = next_ac(m_ac, m_id);
        end else begin
            e = {1'b0, m_ac};
        end
        exp_rd_q.push_back(e);
        bus_cycle(rs, 1'b1, 8'($urandom));
    endtask

    task automatic check_dbg(input logic [6:0] a);
        @(negedge clk);
        dbg_addr = a;
        @(negedge clk);
        check("dbg_char", dbg_char, mapped(a) ? mem[a] : 8'h00);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", busy, 0);
        check("rst_oe", oe, 0);
        check("rst_dout", dout, 0);
        check("rst_strobe", strobe, 0);
        check("rst_cmd_rs", crs, 0);
        check("rst_cmd_byte", cbyte, 0);
        check("rst_write_err", werr, 0);
        check("rst_dbg_char", dbg_char, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rv;
        int r;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        exp_rd_q.push_back(8'h80);
        bus_cycle(1'b0, 1'b1, 8'h00);
        repeat (100) @(negedge clk);
        check("init_busy_len", last_run, 80);
        rd(1'b0);
        check_dbg(7'h00);

        wr(1'b0, 8'h80);
        check("cmd_busy_len", last_run, CMD);
        wr(1'b1, 8'h41);
        rd(1'b0);
        check_dbg(7'h00);

        wr(1'b0, 8'hA7);
        wr(1'b1, 8'h5A);
        rd(1'b0);
        wr(1'b0, 8'h04);
        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h31);
        rd(1'b0);
        wr(1'b0, 8'h80);
        wr(1'b1, 8'h32);
        rd(1'b0);
        wr(1'b0, 8'h06);

        exp_wr_q.push_back(9'h001);
        model_write(1'b0, 8'h01);
        bus_cycle(1'b0, 1'b0, 8'h01);
        bus_cycle(1'b1, 1'b0, 8'h33);
        repeat (CLR) @(negedge clk);
        check("write_err_sticky", werr, 1);
        check("clear_busy_len", last_run, CLR);
        for (int a = 0; a < 128; a++)
            if (mapped(7'(a))) check_dbg(7'(a));
        rd(1'b0);

        wr(1'b0, 8'hC0);
        wr(1'b1, 8'h55);
        wr(1'b0, 8'hC0);
        rd(1'b1);
        rd(1'b0);

        for (int n = 0; n < 160; n++) begin
            rv = $urandom;
            r = $urandom_range(0, 99);
            if (r < 30) wr(1'b1, rv[7:0]);
            else if (r < 45) rd(mapped(m_ac));
            else if (r < 55) rd(1'b0);
            else if (r < 70) wr(1'b0, {1'b1, rv[6:0]});
            else if (r < 76) wr(1'b0, {6'b000001, rv[1:0]});
            else if (r < 80) wr(1'b0, {7'b0000001, rv[0]});
            else if (r < 86) wr(1'b0, {5'b00001, rv[2:0]});
            else if (r < 90) wr(1'b0, {3'b001, rv[4:0]});
            else if (r < 93) wr(1'b0, {4'b0001, rv[3:0]});
            else if (r < 96) wr(1'b0, {2'b01, rv[5:0]});
            else if (r < 98) wr(1'b0, 8'h00);
            else wr(1'b0, 8'h01);
            if (rv[31:29] == 3'b000) check_dbg(rv[22:16]);
        end
        for (int a = 0; a < 128; a++) check_dbg(7'(a));
        rd(1'b0);

        exp_wr_q.push_back(9'h008);
        bus_cycle(1'b0, 1'b0, 8'h08);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        model_reset();
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("reinit_busy_len", last_run, 80);
        rd(1'b0);
        wr(1'b1, 8'h77);
        check_dbg(7'h00);
        check_dbg(7'h01);
        rd(1'b0);

        repeat (5) @(negedge clk);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
